// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master round-robin Wishbone arbiter.
package wb_arb_pkg;

    // Arbiter states: idle, owned by master 0 or 1, and a one-cycle abort
    // that kills the slave cycle after a watchdog timeout.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } arb_state_e;

    // Pick the next owner from the pending CYC requests. A lone requester
    // wins outright; on a tie the priority pointer decides.
    function automatic logic next_owner(input logic [1:0] cyc, input logic prio);
        logic owner;
        case (cyc)
            2'b01:   owner = 1'b0;
            2'b10:   owner = 1'b1;
            2'b11:   owner = prio;
            default: owner = prio;
        endcase
        return owner;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Ack watchdog: counts cycles while a transaction is waiting for a response
// and raises a single-cycle fire pulse when the budget is exhausted.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic fire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins; otherwise saturating increment while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fire exactly on the last budgeted cycle; the owner leaves right after,
    // so the pulse is one cycle wide.
    always_comb begin
        fire = run & ~clr & (cnt_q == CNT_LAST);
    end

endmodule

// File: rtl/wb_rr_arbiter_2to1.sv
// Two-master round-robin arbiter in front of one pipelined Wishbone slave.
// A grant lasts for the owner's whole CYC; strobes are throttled by an
// outstanding-transaction limit and a stuck slave is cut off by a watchdog.
module wb_rr_arbiter_2to1
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int MAX_OUTST   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              m_cyc,
    input  logic [1:0]              m_stb,
    input  logic [1:0]              m_we,
    input  logic [2*ADDR_W-1:0]     m_adr,
    input  logic [2*DATA_W/8-1:0]   m_sel,
    input  logic [2*DATA_W-1:0]     m_dat_w,
    output logic [DATA_W-1:0]       m_dat_r,
    output logic [1:0]              m_stall,
    output logic [1:0]              m_ack,
    output logic [1:0]              m_err,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_adr,
    output logic [DATA_W/8-1:0]     s_sel,
    output logic [DATA_W-1:0]       s_dat_w,
    input  logic [DATA_W-1:0]       s_dat_r,
    input  logic                    s_stall,
    input  logic                    s_ack,
    input  logic                    s_err,
    output logic [1:0]              grant
);

    localparam int SEL_W   = DATA_W / 8;
    localparam int OUTST_W = $clog2(MAX_OUTST + 1);
    localparam logic [OUTST_W-1:0] OUTST_FULL = OUTST_W'(MAX_OUTST);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic                prio_q;
    logic                prio_d;
    logic [OUTST_W-1:0]  outst_q;
    logic [OUTST_W-1:0]  outst_d;

    logic own_s;        // some master owns the slave
    logic owner_s;      // index of the owning master
    logic own_cyc_s;    // owner still holds CYC
    logic full_s;       // outstanding limit reached
    logic rsp_s;        // slave returned ack or err
    logic rsp_ok_s;     // a response may be forwarded/counted
    logic dec_s;        // outstanding count drops this cycle
    logic issue_s;      // strobe accepted by the slave this cycle
    logic wd_run_s;
    logic wd_clr_s;
    logic wd_fire_s;

    // Decode ownership and the bus events of the current cycle.
    always_comb begin
        own_s     = (state_q == OWN0) || (state_q == OWN1);
        owner_s   = (state_q == OWN1);
        own_cyc_s = own_s & (owner_s ? m_cyc[1] : m_cyc[0]);
        full_s    = (outst_q == OUTST_FULL);
        rsp_s     = s_ack | s_err;
        // Responses with nothing outstanding are stale (from a released
        // cycle) and are swallowed instead of reaching the new owner.
        rsp_ok_s  = own_cyc_s & (outst_q != '0);
        dec_s     = rsp_s & rsp_ok_s;
        wd_run_s  = own_cyc_s & (outst_q != '0) & ~rsp_s;
        wd_clr_s  = ~own_cyc_s | rsp_s | (outst_q == '0);
    end

    wb_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr_s),
        .run   (wd_run_s),
        .fire  (wd_fire_s)
    );

    // Route the owning master onto the slave port; strobes are held back
    // when full or while the watchdog is tearing the cycle down.
    always_comb begin
        s_cyc   = own_cyc_s;
        s_stb   = own_cyc_s & (owner_s ? m_stb[1] : m_stb[0]) & ~full_s & ~wd_fire_s;
        s_we    = owner_s ? m_we[1] : m_we[0];
        s_adr   = owner_s ? m_adr[2*ADDR_W-1:ADDR_W] : m_adr[ADDR_W-1:0];
        s_sel   = owner_s ? m_sel[2*SEL_W-1:SEL_W] : m_sel[SEL_W-1:0];
        s_dat_w = owner_s ? m_dat_w[2*DATA_W-1:DATA_W] : m_dat_w[DATA_W-1:0];
        issue_s = s_stb & ~s_stall;
        m_dat_r = s_dat_r;
    end

    // Master-side handshake: the non-owner is always stalled and never
    // sees a response; the owner gets an error pulse when the watchdog fires.
    always_comb begin
        m_stall = 2'b11;
        m_ack   = 2'b00;
        m_err   = 2'b00;
        grant   = 2'b00;
        if (own_s) begin
            grant[owner_s]   = 1'b1;
            m_stall[owner_s] = s_stall | full_s | wd_fire_s;
            m_ack[owner_s]   = s_ack & rsp_ok_s;
            m_err[owner_s]   = (s_err & rsp_ok_s) | wd_fire_s;
        end else begin
            m_stall = 2'b11;
            m_ack   = 2'b00;
            m_err   = 2'b00;
            grant   = 2'b00;
        end
    end

    // Next state, round-robin pointer and outstanding-strobe count.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        outst_d = outst_q;
        case (state_q)
            IDLE: begin
                outst_d = '0;
                if (m_cyc != 2'b00) begin
                    state_d = next_owner(m_cyc, prio_q) ? OWN1 : OWN0;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc_s) begin
                    // Owner released: the other master gets the next tie.
                    state_d = IDLE;
                    outst_d = '0;
                    prio_d  = ~owner_s;
                end else if (wd_fire_s) begin
                    state_d = ABORT;
                    outst_d = '0;
                    prio_d  = ~owner_s;
                end else begin
                    state_d = state_q;
                    if (issue_s && !dec_s) begin
                        outst_d = outst_q + 1'b1;
                    end else if (!issue_s && dec_s) begin
                        outst_d = outst_q - 1'b1;
                    end else begin
                        outst_d = outst_q;
                    end
                end
            end
            ABORT: begin
                state_d = IDLE;
                outst_d = '0;
            end
            default: begin
                state_d = IDLE;
                outst_d = '0;
            end
        endcase
    end

    // State, pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            outst_q <= outst_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter_2to1.sv
// Directed self-checking bench for wb_rr_arbiter_2to1 with a bench-side
// master model, a latency-programmable slave model and per-master
// read-data scoreboards.
module tb_wb_rr_arbiter_2to1;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [59:0] m_adr;
    logic [7:0]  m_sel;
    logic [63:0] m_dat_w;
    logic [31:0] m_dat_r;
    logic [1:0]  m_stall, m_ack, m_err;
    logic        s_cyc, s_stb, s_we;
    logic [29:0] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_w, s_dat_r;
    logic        s_stall, s_ack, s_err;
    logic [1:0]  grant;

    wb_rr_arbiter_2to1 #(
        .ADDR_W(30), .DATA_W(32), .MAX_OUTST(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_sel(m_sel), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r),
        .m_stall(m_stall), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_sel(s_sel), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r),
        .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;

    // master model
    int          mreq [2];
    logic [29:0] madr [2];
    logic [1:0]  mwe;
    logic [3:0]  msel [2];
    logic [31:0] mdw  [2];
    logic [31:0] sb0 [$];
    logic [31:0] sb1 [$];
    int          ack_cnt [2];
    int          err_cnt [2];
    int          issue_cyc;
    int          first_err_cyc;
    int          acc_at_first_ack;
    int          m0_acc;
    logic        m1_unstall_seen;

    // slave model
    int          slv_lat;
    logic        slv_mute;
    int          pend_due [$];
    logic [31:0] pend_dat [$];
    int          slv_acc;
    int          max_pend;
    logic        last_s_we;
    logic [3:0]  last_s_sel;
    logic [31:0] last_s_dw;
    logic [29:0] last_s_adr;

    // observations of the most recent step
    logic [1:0]  obs_ack, obs_err, obs_grant, obs_stall;
    logic        obs_scyc;

    function automatic logic [31:0] pat(input logic [29:0] a);
        return {a, 2'b01} ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_bench();
        pend_due.delete();
        pend_dat.delete();
        sb0.delete();
        sb1.delete();
        mreq[0] = 0;
        mreq[1] = 0;
    endtask

    task automatic clear_stats();
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        err_cnt[0] = 0; err_cnt[1] = 0;
        first_err_cyc = -1;
        acc_at_first_ack = -1;
        slv_acc = 0;
        max_pend = 0;
        m0_acc = 0;
        m1_unstall_seen = 1'b0;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step();
        logic [31:0] exp_d;
        int          tmp_i;
        m_stb   = {(mreq[1] != 0), (mreq[0] != 0)};
        m_adr   = {madr[1], madr[0]};
        m_we    = mwe;
        m_sel   = {msel[1], msel[0]};
        m_dat_w = {mdw[1], mdw[0]};
        if (!slv_mute && pend_due.size() > 0 && pend_due[0] <= cyc_cnt) begin
            s_ack   = 1'b1;
            s_dat_r = pend_dat.pop_front();
            tmp_i   = pend_due.pop_front();
        end else begin
            s_ack   = 1'b0;
            s_dat_r = 32'h0BAD_0BAD;
        end
        #1;
        obs_ack = m_ack; obs_err = m_err; obs_grant = grant;
        obs_stall = m_stall; obs_scyc = s_cyc;
        if (!m_stall[1]) m1_unstall_seen = 1'b1;
        if (m_ack[0]) begin
            if (ack_cnt[0] == 0) acc_at_first_ack = slv_acc;
            ack_cnt[0]++;
            chk("m0_ack_expected", 64'(sb0.size() != 0), 64'd1);
            if (sb0.size() != 0) begin
                exp_d = sb0.pop_front();
                chk("m0_rdata", 64'(m_dat_r), 64'(exp_d));
            end
        end
        if (m_ack[1]) begin
            ack_cnt[1]++;
            chk("m1_ack_expected", 64'(sb1.size() != 0), 64'd1);
            if (sb1.size() != 0) begin
                exp_d = sb1.pop_front();
                chk("m1_rdata", 64'(m_dat_r), 64'(exp_d));
            end
        end
        for (int n = 0; n < 2; n++) begin
            if (m_err[n]) begin
                err_cnt[n]++;
                if (first_err_cyc < 0) first_err_cyc = cyc_cnt;
            end
            if (m_cyc[n] && m_stb[n] && !m_stall[n]) begin
                if (n == 0) begin sb0.push_back(pat(madr[0])); m0_acc++; end
                else        sb1.push_back(pat(madr[1]));
                issue_cyc = cyc_cnt;
                madr[n] = madr[n] + 30'd1;
                mreq[n] = mreq[n] - 1;
            end
        end
        if (s_cyc && s_stb && !s_stall) begin
            pend_due.push_back(cyc_cnt + slv_lat);
            pend_dat.push_back(pat(s_adr));
            slv_acc++;
            last_s_we = s_we; last_s_sel = s_sel; last_s_dw = s_dat_w; last_s_adr = s_adr;
            if (pend_due.size() > max_pend) max_pend = pend_due.size();
        end
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_bench();
    endtask

    initial begin
        rst_n = 1'b0;
        m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00; m_adr = '0; m_sel = '0; m_dat_w = '0;
        s_dat_r = 32'h0; s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0;
        mwe = 2'b00;
        madr[0] = 30'h0; madr[1] = 30'h0;
        msel[0] = 4'hF; msel[1] = 4'hF;
        mdw[0] = 32'h0; mdw[1] = 32'h0;
        slv_lat = 1; slv_mute = 1'b0;
        issue_cyc = 0;
        last_s_we = 1'b0; last_s_sel = 4'h0; last_s_dw = 32'h0; last_s_adr = 30'h0;
        clear_bench();
        clear_stats();

        // reset state
        #2;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_stall", 64'(m_stall), 64'h3);
        chk("rst_scyc", 64'({s_cyc, s_stb}), 64'd0);
        chk("rst_ack_err", 64'({m_ack, m_err}), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: single master read of 0x4
        clear_stats();
        m_cyc = 2'b01; mreq[0] = 1; madr[0] = 30'h4; slv_lat = 1;
        step();
        chk("t1_idle_grant", 64'(obs_grant), 64'd0);
        chk("t1_idle_stall", 64'(obs_stall), 64'h3);
        s_stall = 1'b1;
        step();
        chk("t1_grant", 64'(obs_grant), 64'h1);
        chk("t1_slave_stall", 64'(obs_stall), 64'h3);
        s_stall = 1'b0;
        for (int k = 0; k < 8 && ack_cnt[0] < 1; k++) step();
        chk("t1_acks", 64'(ack_cnt[0]), 64'd1);
        chk("t1_m1_stalled", 64'(m1_unstall_seen), 64'd0);
        chk("t1_sadr", 64'(last_s_adr), 64'h4);
        m_cyc = 2'b00;
        step();
        step();
        chk("t1_release", 64'(obs_grant), 64'd0);

        // 2: ties alternate
        do_reset();
        m_cyc = 2'b11;
        step();
        chk("t2_idle", 64'(obs_grant), 64'd0);
        step();
        chk("t2_first_m0", 64'(obs_grant), 64'h1);
        chk("t2_stall", 64'(obs_stall), 64'h2);
        m_cyc = 2'b10;
        step();
        step();
        chk("t2_gap_idle", 64'(obs_grant), 64'd0);
        step();
        chk("t2_then_m1", 64'(obs_grant), 64'h2);
        chk("t2_m1_stall", 64'(obs_stall), 64'h1);
        m_cyc = 2'b00;
        step();
        step();
        m_cyc = 2'b11;
        step();
        step();
        chk("t2_tie_m0", 64'(obs_grant), 64'h1);
        m_cyc = 2'b00;
        step();
        step();

        // 3: pipelining against the outstanding limit
        clear_stats();
        m_cyc = 2'b01; mreq[0] = 6; madr[0] = 30'h100; slv_lat = 8;
        for (int k = 0; k < 40 && ack_cnt[0] < 6; k++) step();
        chk("t3_acks", 64'(ack_cnt[0]), 64'd6);
        chk("t3_max_outst", 64'(max_pend), 64'd4);
        chk("t3_slv_before_ack", 64'(acc_at_first_ack), 64'd4);
        chk("t3_m0_accepts", 64'(m0_acc), 64'd6);
        m_cyc = 2'b00;
        step();
        step();

        // 4: watchdog on a silent slave, m1 waiting
        clear_bench();
        clear_stats();
        slv_mute = 1'b1; slv_lat = 1;
        m_cyc = 2'b01; mreq[0] = 1; madr[0] = 30'h200;
        step();
        m_cyc = 2'b11;
        for (int k = 0; k < 40 && err_cnt[0] == 0; k++) step();
        chk("t4_err_delay", 64'(first_err_cyc - issue_cyc), 64'd16);
        m_cyc = 2'b10;
        step();
        chk("t4_abort_scyc", 64'(obs_scyc), 64'd0);
        chk("t4_abort_grant", 64'(obs_grant), 64'd0);
        chk("t4_abort_stall", 64'(obs_stall), 64'h3);
        chk("t4_err_pulse", 64'(obs_err), 64'd0);
        step();
        step();
        chk("t4_m1_granted", 64'(obs_grant), 64'h2);
        chk("t4_err_counts", 64'({err_cnt[1][15:0], err_cnt[0][15:0]}), 64'h0000_0001);
        chk("t4_m0_no_ack", 64'(ack_cnt[0]), 64'd0);
        clear_bench();
        slv_mute = 1'b0;

        // 5: m1 abandons two outstanding strobes, late acks are dropped
        clear_stats();
        slv_lat = 3; mreq[1] = 2; madr[1] = 30'h300;
        step();
        step();
        m_cyc = 2'b01;
        step();
        step();
        chk("t5_late_ack_idle", 64'(obs_ack), 64'd0);
        step();
        chk("t5_late_ack_own", 64'(obs_ack), 64'd0);
        chk("t5_m0_grant", 64'(obs_grant), 64'h1);
        chk("t5_no_acks", 64'(ack_cnt[0] + ack_cnt[1]), 64'd0);
        sb1.delete();
        mwe = 2'b01; msel[0] = 4'h3; mdw[0] = 32'h1234_5678; madr[0] = 30'h40;
        mreq[0] = 1; slv_lat = 1;
        for (int k = 0; k < 8 && ack_cnt[0] < 1; k++) step();
        chk("t5_m0_ack", 64'(ack_cnt[0]), 64'd1);
        chk("t5_swe", 64'(last_s_we), 64'd1);
        chk("t5_ssel", 64'(last_s_sel), 64'h3);
        chk("t5_sdat", 64'(last_s_dw), 64'h1234_5678);
        chk("t5_sadr", 64'(last_s_adr), 64'h40);
        mwe = 2'b00;

        // 6: async reset in the middle of an m1 burst
        m_cyc = 2'b00;
        step();
        step();
        m_cyc = 2'b10; mreq[1] = 3; madr[1] = 30'h500; slv_lat = 8;
        step();
        step();
        step();
        chk("t6_m1_owns", 64'(obs_grant), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_scyc", 64'(s_cyc), 64'd0);
        chk("t6_rst_stall", 64'(m_stall), 64'h3);
        chk("t6_rst_grant", 64'(grant), 64'd0);
        m_cyc = 2'b00;
        clear_bench();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_cyc = 2'b11;
        step();
        chk("t6_idle", 64'(obs_grant), 64'd0);
        step();
        chk("t6_m0_prio", 64'(obs_grant), 64'h1);
        m_cyc = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
